// File: rtl/aes_pkg.sv
// aes_pkg: shared Rijndael state geometry helpers for the round datapath stages.
package aes_pkg;

    localparam int NB_MAX = 8;

    typedef logic [32*NB_MAX-1:0] state_t;

    typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;

    // 256-bit blocks use offsets {0,1,3,4}; narrower blocks use {0,1,2,3}
    function automatic int row_shift(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic int byte_lsb(input int nb, input int r, input int c);
        return 32*nb - 8 - 8*(4*c + r);
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows byte routing for NB columns.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
)(
    input  logic [32*NB-1:0] in_data,
    input  logic             inv,
    output logic [32*NB-1:0] out_data
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int S  = row_shift(NB, r);
            localparam int CF = (c + S) % NB;
            localparam int CI = (c - S + NB) % NB;
            assign out_data[byte_lsb(NB, r, c) +: 8] = inv ? in_data[byte_lsb(NB, r, CI) +: 8]
                                                           : in_data[byte_lsb(NB, r, CF) +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered, handshaked ShiftRows / InvShiftRows stage with tag sideband
// and optional 2-entry skid buffer.
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 8,
    parameter int SKID  = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [32*NB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [32*NB-1:0] out_data
);

    logic [32*NB-1:0] w_perm;
    logic [32*NB-1:0] r_data;
    logic [TAG_W-1:0] r_tag;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    shift_rows_perm #(.NB(NB)) u_perm (
        .in_data  (in_data),
        .inv      (in_inv),
        .out_data (w_perm)
    );

    assign out_data = r_data;
    assign out_tag  = r_tag;

    if (SKID == 0) begin : g_reg
        logic r_valid;
        assign out_valid = r_valid;
        assign in_ready  = !rst && (!r_valid || out_ready);
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
                r_tag   <= '0;
            end else if (in_valid && in_ready) begin
                r_valid <= 1'b1;
                r_data  <= w_perm;
                r_tag   <= in_tag;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end else begin : g_skid
        occ_t             r_state;
        occ_t             w_state_nxt;
        logic             r_rdy;
        logic [32*NB-1:0] r_sdata;
        logic [TAG_W-1:0] r_stag;
        logic             w_acc;
        logic             w_drn;
        // r_rdy resets high so ready rises on the first cycle after release; rst masks it meanwhile
        assign in_ready  = r_rdy && !rst;
        assign out_valid = (r_state != OCC_EMPTY);
        assign w_acc     = in_valid && in_ready;
        assign w_drn     = out_valid && out_ready;
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                OCC_EMPTY: w_state_nxt = w_acc ? OCC_ONE : OCC_EMPTY;
                OCC_ONE:   w_state_nxt = (w_acc && !w_drn) ? OCC_FULL :
                                         (!w_acc && w_drn) ? OCC_EMPTY : OCC_ONE;
                OCC_FULL:  w_state_nxt = w_drn ? OCC_ONE : OCC_FULL;
                default:   w_state_nxt = OCC_EMPTY;
            endcase
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= OCC_EMPTY;
                r_rdy   <= 1'b1;
                r_data  <= '0;
                r_tag   <= '0;
                r_sdata <= '0;
                r_stag  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_rdy   <= (w_state_nxt != OCC_FULL);
                if ((r_state == OCC_EMPTY && w_acc) || (r_state == OCC_ONE && w_acc && w_drn)) begin
                    r_data <= w_perm;
                    r_tag  <= in_tag;
                end else if (r_state == OCC_FULL && w_drn) begin
                    r_data <= r_sdata;
                    r_tag  <= r_stag;
                end
                if (r_state == OCC_ONE && w_acc && !w_drn) begin
                    r_sdata <= w_perm;
                    r_stag  <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed checks of shift_rows_pipe for NB=4 (SKID 1 and 0) and NB=8.
module tb_shift_rows_pipe;

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] NB8_IN   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] NB8_OUT  = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic         a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 0;
    logic [7:0]   a_in_tag = 0, a_out_tag;
    logic [127:0] a_in_data = 0, a_out_data;
    logic         b_in_valid = 0, b_in_ready, b_in_inv = 0, b_out_valid, b_out_ready = 0;
    logic [7:0]   b_in_tag = 0, b_out_tag;
    logic [127:0] b_in_data = 0, b_out_data;
    logic         c_in_valid = 0, c_in_ready, c_in_inv = 0, c_out_valid, c_out_ready = 0;
    logic [7:0]   c_in_tag = 0, c_out_tag;
    logic [255:0] c_in_data = 0, c_out_data;

    shift_rows_pipe #(.NB(4), .TAG_W(8), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_tag(a_in_tag), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_tag(a_out_tag), .out_data(a_out_data));

    shift_rows_pipe #(.NB(4), .TAG_W(8), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
        .in_tag(b_in_tag), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_tag(b_out_tag), .out_data(b_out_data));

    shift_rows_pipe #(.NB(8), .TAG_W(8), .SKID(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
        .in_tag(c_in_tag), .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_tag(c_out_tag), .out_data(c_out_data));

    function automatic logic [127:0] sr4(input logic [127:0] d, input logic inv);
        logic [127:0] o;
        int s;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                s = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127-8*(4*c+r) -: 8] = d[127-8*(4*s+r) -: 8];
            end
        return o;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_tag !== '0) begin
            failures++;
            $display("FAIL reset_out_a: valid=%b data=%h tag=%h, want 0/0/0", a_out_valid, a_out_data, a_out_tag);
        end
        checks++;
        if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || b_out_data !== '0 || c_out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_bc: b_valid=%b c_valid=%b, want 0 with zero data", b_out_valid, c_out_valid);
        end
        checks++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || c_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: a=%b b=%b c=%b, want 0", a_in_ready, b_in_ready, c_in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: a=%b b=%b c=%b, want 1", a_in_ready, b_in_ready, c_in_ready);
        end
    endtask

    task automatic test_fips_fwd;
        a_out_ready = 1; b_out_ready = 1;
        @(posedge clk); #1;
        a_in_valid = 1; a_in_inv = 0; a_in_tag = 8'h11; a_in_data = FIPS_IN;
        b_in_valid = 1; b_in_inv = 0; b_in_tag = 8'h22; b_in_data = FIPS_IN;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fwd_ready: a=%b b=%b, want 1", a_in_ready, b_in_ready);
        end
        @(posedge clk); #1;
        a_in_valid = 0; a_in_data = 'x; a_in_inv = 1'bx;
        b_in_valid = 0; b_in_data = 'x; b_in_inv = 1'bx;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== FIPS_OUT || a_out_tag !== 8'h11) begin
            failures++;
            $display("FAIL fwd_a: valid=%b data=%h tag=%h, want 1 %h 11", a_out_valid, a_out_data, a_out_tag, FIPS_OUT);
        end
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== FIPS_OUT || b_out_tag !== 8'h22) begin
            failures++;
            $display("FAIL fwd_b: valid=%b data=%h tag=%h, want 1 %h 22", b_out_valid, b_out_data, b_out_tag, FIPS_OUT);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_out_data !== FIPS_OUT || b_out_data !== FIPS_OUT) begin
            failures++;
            $display("FAIL fwd_drain: a_valid=%b b_valid=%b a=%h b=%h, want 0 0 with data held", a_out_valid, b_out_valid, a_out_data, b_out_data);
        end
    endtask

    task automatic test_fips_inv;
        a_out_ready = 1;
        @(posedge clk); #1;
        a_in_valid = 1; a_in_inv = 1; a_in_tag = 8'h5A; a_in_data = FIPS_OUT;
        @(posedge clk); #1;
        a_in_valid = 0; a_in_data = 'x; a_in_inv = 1'bx; a_in_tag = 8'hFF;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== FIPS_IN || a_out_tag !== 8'h5A) begin
            failures++;
            $display("FAIL inv_a: valid=%b data=%h tag=%h, want 1 %h 5a", a_out_valid, a_out_data, a_out_tag, FIPS_IN);
        end
        @(posedge clk); #1;
        a_in_inv = 0; a_in_tag = 0; a_in_data = 0;
    endtask

    task automatic test_nb8;
        c_out_ready = 1;
        @(posedge clk); #1;
        c_in_valid = 1; c_in_inv = 0; c_in_tag = 8'h08; c_in_data = NB8_IN;
        @(posedge clk); #1;
        c_in_inv = 1; c_in_tag = 8'h09; c_in_data = NB8_OUT;
        @(negedge clk);
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data[255:224] !== 32'h00050e13) begin
            failures++;
            $display("FAIL nb8_col0: valid=%b col0=%h, want 1 00050e13", c_out_valid, c_out_data[255:224]);
        end
        checks++;
        if (c_out_data !== NB8_OUT || c_out_tag !== 8'h08) begin
            failures++;
            $display("FAIL nb8_fwd: data=%h tag=%h, want %h 08", c_out_data, c_out_tag, NB8_OUT);
        end
        @(posedge clk); #1;
        c_in_valid = 0; c_in_data = 'x;
        @(negedge clk);
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== NB8_IN || c_out_tag !== 8'h09) begin
            failures++;
            $display("FAIL nb8_inv: valid=%b data=%h tag=%h, want 1 %h 09", c_out_valid, c_out_data, c_out_tag, NB8_IN);
        end
        @(posedge clk); #1;
        c_in_data = 0; c_in_inv = 0;
    endtask

    task automatic test_backpressure;
        logic [127:0] bp [3];
        int idx, n, gaps, extra;
        logic acc;
        bp[0] = 128'h00112233445566778899aabbccddeeff;
        bp[1] = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        bp[2] = 128'h0123456789abcdeffedcba9876543210;
        a_out_ready = 0; idx = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            a_in_valid = 1; a_in_inv = 0; a_in_tag = 8'hA0 + 8'(idx); a_in_data = bp[idx > 2 ? 2 : idx];
            @(negedge clk);
            acc = a_in_ready;
            if (cyc >= 1) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== sr4(bp[0], 1'b0) || a_out_tag !== 8'hA0) begin
                    failures++;
                    $display("FAIL bp_hold cyc%0d: valid=%b data=%h tag=%h, want 1 %h a0", cyc, a_out_valid, a_out_data, a_out_tag, sr4(bp[0], 1'b0));
                end
            end
            if (acc) idx++;
        end
        checks++;
        if (idx != 2 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accepted: accepted=%0d in_ready=%b, want 2 0", idx, a_in_ready);
        end
        @(posedge clk); #1;
        a_out_ready = 1;
        n = 0; gaps = 0; extra = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_out_valid && n < 3) begin
                checks++;
                if (a_out_data !== sr4(bp[n], 1'b0) || a_out_tag !== 8'hA0 + 8'(n)) begin
                    failures++;
                    $display("FAIL bp_order beat%0d: data=%h tag=%h, want %h %h", n, a_out_data, a_out_tag, sr4(bp[n], 1'b0), 8'hA0 + 8'(n));
                end
                n++;
            end else if (a_out_valid) begin
                extra++;
            end else if (n > 0 && n < 3) begin
                gaps++;
            end
            @(posedge clk); #1;
            if (acc) a_in_valid = 0;
        end
        checks++;
        if (n != 3 || gaps != 0 || extra != 0) begin
            failures++;
            $display("FAIL bp_drain: beats=%0d gaps=%0d extra=%0d, want 3 0 0", n, gaps, extra);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] vec [16];
        logic [127:0] exp_d;
        for (int i = 0; i < 16; i++) vec[i] = {$urandom, $urandom, $urandom, $urandom};
        a_out_ready = 1; b_out_ready = 1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(posedge clk); #1;
            a_in_valid = (cyc < 16); b_in_valid = (cyc < 16);
            if (cyc < 16) begin
                a_in_data = vec[cyc]; a_in_tag = 8'(cyc); a_in_inv = cyc[0];
                b_in_data = vec[cyc]; b_in_tag = 8'(cyc + 32); b_in_inv = cyc[0];
            end
            @(negedge clk);
            if (cyc < 16) begin
                checks++;
                if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready cyc%0d: a=%b b=%b, want 1", cyc, a_in_ready, b_in_ready);
                end
            end
            if (cyc >= 1 && cyc <= 16) begin
                exp_d = sr4(vec[cyc-1], (cyc - 1) % 2 == 1);
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== exp_d || a_out_tag !== 8'(cyc - 1)) begin
                    failures++;
                    $display("FAIL b2b_a beat%0d: valid=%b data=%h tag=%h, want 1 %h %h", cyc - 1, a_out_valid, a_out_data, a_out_tag, exp_d, 8'(cyc - 1));
                end
                checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== exp_d || b_out_tag !== 8'(cyc + 31)) begin
                    failures++;
                    $display("FAIL b2b_b beat%0d: valid=%b data=%h tag=%h, want 1 %h %h", cyc - 1, b_out_valid, b_out_data, b_out_tag, exp_d, 8'(cyc + 31));
                end
            end
        end
        checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_tail: a_valid=%b b_valid=%b, want 0 0", a_out_valid, b_out_valid);
        end
    endtask

    task automatic test_reset_full;
        a_out_ready = 0;
        @(posedge clk); #1;
        a_in_valid = 1; a_in_inv = 0; a_in_tag = 8'h01; a_in_data = FIPS_IN;
        @(posedge clk); #1;
        a_in_tag = 8'h02; a_in_data = FIPS_OUT;
        @(posedge clk); #1;
        a_in_valid = 0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_data !== FIPS_OUT || a_out_tag !== 8'h01) begin
            failures++;
            $display("FAIL rf_full: in_ready=%b valid=%b data=%h tag=%h, want 0 1 %h 01", a_in_ready, a_out_valid, a_out_data, a_out_tag, FIPS_OUT);
        end
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rf_ready_in_rst: in_ready=%b, want 0", a_in_ready);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_tag !== '0 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rf_cleared: valid=%b data=%h tag=%h in_ready=%b, want 0 0 0 0", a_out_valid, a_out_data, a_out_tag, a_in_ready);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rf_release: in_ready=%b valid=%b, want 1 0", a_in_ready, a_out_valid);
        end
        a_out_ready = 1;
        @(posedge clk); #1;
        a_in_valid = 1; a_in_inv = 0; a_in_tag = 8'h77; a_in_data = FIPS_IN;
        @(posedge clk); #1;
        a_in_valid = 0;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== FIPS_OUT || a_out_tag !== 8'h77) begin
            failures++;
            $display("FAIL rf_post_beat: valid=%b data=%h tag=%h, want 1 %h 77", a_out_valid, a_out_data, a_out_tag, FIPS_OUT);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rf_no_dup: valid=%b, want 0", a_out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_fips_fwd;
        test_fips_inv;
        test_nb8;
        test_backpressure;
        test_back_to_back;
        test_reset_full;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
